// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-side and result signals of alu_cmd_issuer, bundled with master/slave views.
// When ALU_CHAIN_EN is defined the command channel also carries in_chain.
interface alu_cmd_issuer_if #(
    parameter int AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic [1:0]    in_op;
`ifdef ALU_CHAIN_EN
    logic          in_chain;
`endif
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [1:0]    alu_op;
    logic [3:0]    alu_out;
    logic          alu_extra;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_out;
    logic          res_extra;
    logic [1:0]    res_op;
    logic          res_dz;
    logic [AW:0]   fifo_count;

    // The issuer itself.
    modport slave (
`ifdef ALU_CHAIN_EN
        input  in_chain,
`endif
        input  in_valid, in_a, in_b, in_op, alu_out, alu_extra, res_ready,
        output in_ready, alu_a, alu_b, alu_op,
        output res_valid, res_out, res_extra, res_op, res_dz, fifo_count
    );

    // Command producer, ALU and result consumer seen as one environment.
    modport master (
`ifdef ALU_CHAIN_EN
        output in_chain,
`endif
        output in_valid, in_a, in_b, in_op, alu_out, alu_extra, res_ready,
        input  in_ready, alu_a, alu_b, alu_op,
        input  res_valid, res_out, res_extra, res_op, res_dz, fifo_count
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands in a small FIFO, issues them to a 4-bit combinational ALU and holds
// each 5-bit result on a valid/ready port. Optional feature macro: ALU_CHAIN_EN.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic           clk,
    input logic           rst,
    alu_cmd_issuer_if.slave bus
);

    typedef struct packed {
`ifdef ALU_CHAIN_EN
        logic       chain;
`endif
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [1:0]  OP_DIV  = 2'b10;
    localparam logic [AW:0] FULL_CT = (AW + 1)'(DEPTH);

    cmd_t          mem [DEPTH];
    cmd_t          in_cmd;
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          load_res;
    logic          drop_res;
    logic          div_zero;
    logic [3:0]    src_a;

    state_t        state_q;
    state_t        state_d;

    logic [3:0]    alu_a_q;
    logic [3:0]    alu_b_q;
    logic [1:0]    alu_op_q;
    logic          res_valid_q;
    logic [3:0]    res_out_q;
    logic          res_extra_q;
    logic [1:0]    res_op_q;
    logic          res_dz_q;

    assign full  = (count == FULL_CT);
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;
    assign head  = mem[rd_ptr];

    always_comb begin
        in_cmd.a  = bus.in_a;
        in_cmd.b  = bus.in_b;
        in_cmd.op = bus.in_op;
`ifdef ALU_CHAIN_EN
        in_cmd.chain = bus.in_chain;
`endif
    end

`ifdef ALU_CHAIN_EN
    // A chained command takes operand A from the result register rather than the queue.
    assign src_a = head.chain ? res_out_q : head.a;
`else
    assign src_a = head.a;
`endif

    // NOTE: storage is not reset; only pointers and count are, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_cmd;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: a default before the case keeps combinational blocks free of inferred latches.
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = SAMPLE;
            SAMPLE:  state_d = HOLD;
            HOLD:    if (bus.res_ready) state_d = empty ? IDLE : SAMPLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        load_res = 1'b0;
        drop_res = 1'b0;
        case (state_q)
            IDLE:   pop = !empty;
            SAMPLE: load_res = 1'b1;
            HOLD: begin
                if (bus.res_ready) begin
                    drop_res = 1'b1;
                    pop      = !empty;
                end
            end
            default: ;
        endcase
    end

    // The ALU output is undefined for a zero divisor, so that case never samples it.
    assign div_zero = (alu_op_q == OP_DIV) && (alu_b_q == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_extra_q <= 1'b0;
            res_op_q    <= '0;
            res_dz_q    <= 1'b0;
        end else begin
            if (pop) begin
                alu_a_q  <= src_a;
                alu_b_q  <= head.b;
                alu_op_q <= head.op;
            end
            if (load_res) begin
                res_valid_q <= 1'b1;
                res_op_q    <= alu_op_q;
                res_dz_q    <= div_zero;
                if (div_zero) begin
                    res_out_q   <= 4'hF;
                    res_extra_q <= 1'b1;
                end else begin
                    res_out_q   <= bus.alu_out;
                    res_extra_q <= bus.alu_extra;
                end
            end else if (drop_res) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = !full;
    assign bus.fifo_count = count;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_out    = res_out_q;
    assign bus.res_extra  = res_extra_q;
    assign bus.res_op     = res_op_q;
    assign bus.res_dz     = res_dz_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: behavioural ALU, in-order result model, directed
// cases and a randomized phase. Honours ALU_CHAIN_EN when defined.
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef ALU_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [7:0] exp_q[$];   // {dz, op[1:0], extra, out[3:0]} in issue order
    int         hs_q[$];    // cycle stamps of result handshakes
    logic [3:0] last_out = 4'd0;

    alu_cmd_issuer_if #(.AW(AW)) u_if ();

    alu_cmd_issuer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; a zero divisor yields an arbitrary pattern the guard must hide.
    always_comb begin
        logic [4:0] r;
        r = 5'd0;
        case (u_if.alu_op)
            2'b00: r = 5'(u_if.alu_a) + 5'(u_if.alu_b);
            2'b01: r = 5'(u_if.alu_a) * 5'(u_if.alu_b);
            2'b10: r = (u_if.alu_b == 4'd0) ? 5'h0A : 5'(u_if.alu_a / u_if.alu_b);
            default: r = 5'(u_if.alu_a) - 5'(u_if.alu_b);
        endcase
        {u_if.alu_extra, u_if.alu_out} = r;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_res(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = (a + b) % 32;
            1: r = (a * b) % 32;
            2: begin
                if (b == 0) return {1'b1, 2'b10, 5'h1F};
                r = a / b;
            end
            default: r = (a - b + 32) % 32;
        endcase
        return {1'b0, 2'(op), 5'(r)};
    endfunction

    // Result monitor: checks the held result every cycle it is valid, retires it on handshake.
    always @(negedge clk) begin
        if (!rst && u_if.res_valid) begin
            check("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("result", {u_if.res_dz, u_if.res_op, u_if.res_extra, u_if.res_out}, exp_q[0]);
                if (u_if.res_ready) begin
                    void'(exp_q.pop_front());
                    hs_q.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after an edge, when in_ready is stable until the next edge.
    task automatic send(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic ch);
        logic [3:0] eff_a;
        logic [7:0] r;
        u_if.in_valid = v;
        u_if.in_a     = a;
        u_if.in_b     = b;
        u_if.in_op    = op;
`ifdef ALU_CHAIN_EN
        u_if.in_chain = ch;
`endif
        if (v && u_if.in_ready) begin
            eff_a = (CHAIN && ch) ? last_out : a;
            r = ref_res(int'(eff_a), int'(b), int'(op));
            exp_q.push_back(r);
            last_out = r[3:0];
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        check("drain_done", exp_q.size(), 0);
        repeat (2) step();
    endtask

    initial begin
        u_if.in_valid  = 1'b0;
        u_if.in_a      = '0;
        u_if.in_b      = '0;
        u_if.in_op     = '0;
        u_if.res_ready = 1'b0;
`ifdef ALU_CHAIN_EN
        u_if.in_chain  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", u_if.res_valid, 0);
        check("rst_in_ready", u_if.in_ready, 1);
        check("rst_count", u_if.fifo_count, 0);
        check("rst_alu", {u_if.alu_a, u_if.alu_b, u_if.alu_op}, 0);
        check("rst_res", {u_if.res_dz, u_if.res_op, u_if.res_extra, u_if.res_out}, 0);
        rst = 1'b0;
        step();

        // Add with latency: accepted at E0, popped at E1, valid after E2.
        u_if.res_ready = 1'b1;
        send(1'b1, 4'd9, 4'd8, 2'b00, 1'b0);
        step();
        send(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        check("lat_e0_valid", u_if.res_valid, 0);
        check("lat_e0_count", u_if.fifo_count, 1);
        step();
        check("lat_e1_valid", u_if.res_valid, 0);
        check("lat_e1_count", u_if.fifo_count, 0);
        check("lat_e1_alu", {u_if.alu_a, u_if.alu_b, u_if.alu_op}, {4'd9, 4'd8, 2'b00});
        step();
        check("lat_e2_valid", u_if.res_valid, 1);
        drain();

        // Mul then sub: in order, two cycles apart.
        hs_q.delete();
        send(1'b1, 4'd4, 4'd5, 2'b01, 1'b0);
        step();
        send(1'b1, 4'd3, 4'd5, 2'b11, 1'b0);
        step();
        send(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        drain();
        check("mulsub_count", hs_q.size(), 2);
        if (hs_q.size() == 2) check("mulsub_gap", hs_q[1] - hs_q[0], 2);

        // Divide, then divide by zero.
        send(1'b1, 4'd9, 4'd2, 2'b10, 1'b0);
        step();
        send(1'b1, 4'd9, 4'd0, 2'b10, 1'b0);
        step();
        send(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        drain();
        check("dz_held", {u_if.res_dz, u_if.res_extra, u_if.res_out}, 6'h3F);

        // Backpressure: six back-to-back, five fit.
        u_if.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 4'(i + 1), 4'd3, 2'b00, 1'b0);
            step();
        end
        check("bp_in_ready", u_if.in_ready, 0);
        check("bp_count", u_if.fifo_count, DEPTH);
        check("bp_accepted", exp_q.size(), 5);
        send(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        u_if.res_ready = 1'b1;
        step();
        check("bp_ready_back", u_if.in_ready, 1);
        check("bp_count_dec", u_if.fifo_count, DEPTH - 1);
        drain();

        // Asynchronous reset with three queued and one result held.
        u_if.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 4'(i + 2), 4'd1, 2'b11, 1'b0);
            step();
        end
        send(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        step();
        check("pre_rst_valid", u_if.res_valid, 1);
        check("pre_rst_count", u_if.fifo_count, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_res_valid", u_if.res_valid, 0);
        check("arst_count", u_if.fifo_count, 0);
        check("arst_in_ready", u_if.in_ready, 1);
        check("arst_outs", {u_if.alu_a, u_if.alu_b, u_if.alu_op, u_if.res_out, u_if.res_op}, 0);
        exp_q.delete();
        last_out = 4'd0;
        step();
        rst = 1'b0;
        u_if.res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_stale", u_if.res_valid, 0);
        end

`ifdef ALU_CHAIN_EN
        send(1'b1, 4'd2, 4'd3, 2'b00, 1'b0);
        step();
        send(1'b1, 4'd0, 4'd4, 2'b00, 1'b1);
        step();
        send(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        drain();
        check("chain_res", u_if.res_out, 4'd9);
`endif

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] b;
            b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
            u_if.res_ready = ($urandom_range(0, 3) != 0);
            send(1'($urandom), 4'($urandom), b, 2'($urandom), 1'($urandom));
            step();
        end
        send(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        u_if.res_ready = 1'b1;
        drain();
        check("final_count", u_if.fifo_count, 0);
        check("final_valid", u_if.res_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
